resp_uart_tx: RTL and testbench

Response transmit path downstream of cmd_dispatcher. It accepts response bytes on the dispatcher's data_out_tx/out_tx_en strobe and buffers them in a small FIFO. It serializes each byte as 8N1 UART (LSB first) on the board TX pin. This block closes the loop: uart_rx → cmd_parser → cmd_fifo → cmd_dispatcher → resp_uart_tx.

---
 rtl/uart_pkg.sv | 15 +
 rtl/resp_fifo.sv | 82 ++++++++
 rtl/resp_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_resp_uart_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the response UART transmit path.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int UART_DATA_BITS       = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data, registered
// full/empty flags and a one-cycle overflow pulse for dropped writes.
module resp_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   count
);

    typedef logic [ADDR_WIDTH:0]   count_t;
    typedef logic [ADDR_WIDTH-1:0] ptr_t;

    localparam count_t COUNT_FULL = count_t'(DEPTH);
    localparam count_t COUNT_ONE  = count_t'(1);
    localparam ptr_t   PTR_ONE    = ptr_t'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    ptr_t             wr_ptr_q;
    ptr_t             rd_ptr_q;
    count_t           count_q;
    count_t           count_d;
    logic             full_q;
    logic             empty_q;
    logic             overflow_q;
    logic             push;
    logic             pop;

    // Full is sampled before any pop, so a write while full is always dropped.
    assign push = wr_en && !full_q;
    assign pop  = rd_en && !empty_q;

    // NOTE: give every always_comb output a default first so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q    <= count_d;
            full_q     <= (count_d == COUNT_FULL);
            empty_q    <= (count_d == '0);
            overflow_q <= wr_en && full_q;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;
    assign count    = count_q;

endmodule

// File: rtl/resp_uart_tx.sv
// Response transmitter: buffers dispatcher bytes and sends them as 8N1 UART,
// or 8E1 when RESP_UART_PARITY_EN is defined.
module resp_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_WIDTH   = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] data_in,
    input  logic                      data_in_en,
    output logic                      fifo_full,
    output logic                      fifo_empty,
    output logic                      overflow,
    output logic                      tx_busy,
    output logic                      tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef logic [BAUD_W-1:0] baud_t;

    localparam baud_t    BAUD_LAST = baud_t'(CLKS_PER_BIT - 1);
    localparam baud_t    BAUD_ONE  = baud_t'(1);
    localparam logic [2:0] IDX_LAST = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    baud_t                     baud_q, baud_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      pop;
    logic                      baud_last;
    logic [UART_DATA_BITS-1:0] fifo_rd_data;
    logic [ADDR_WIDTH:0]       fifo_count;
`ifdef RESP_UART_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    resp_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (UART_DATA_BITS)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (data_in_en),
        .wr_data  (data_in),
        .rd_en    (pop),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (overflow),
        .count    (fifo_count)
    );

    assign baud_last = (baud_q == BAUD_LAST);

    // tx and tx_busy are registered from the current state, so they lag the FSM by one edge.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        busy_d    = 1'b1;
        pop       = 1'b0;
`ifdef RESP_UART_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_d  = fifo_rd_data;
                    baud_d   = '0;
                    state_d  = START;
`ifdef RESP_UART_PARITY_EN
                    parity_d = ^fifo_rd_data;
`endif
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_last) begin
                    baud_d    = '0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == IDX_LAST) begin
`ifdef RESP_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`ifdef RESP_UART_PARITY_EN
            PARITY: begin
                tx_d = parity_q;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef RESP_UART_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef RESP_UART_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

    count_bound_a: assert property (@(posedge clk) disable iff (!rst)
        fifo_count <= (ADDR_WIDTH + 1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_resp_uart_tx.sv
// Directed bench for resp_uart_tx with CLKS_PER_BIT=4; follows RESP_UART_PARITY_EN.
module tb_resp_uart_tx;

    localparam int CPB = 4;
`ifdef RESP_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_en = 1'b0;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;
    logic       tx_busy;
    logic       tx;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        string      name;
    } vec_t;

    vec_t vecs [6];

    resp_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_in_en (data_in_en),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow),
        .tx_busy    (tx_busy),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the byte is captured on the following posedge.
    task automatic write_byte(input logic [7:0] d);
        data_in    = d;
        data_in_en = 1'b1;
        @(negedge clk);
        data_in_en = 1'b0;
    endtask

    // Waits for the start bit, then checks every sample of the frame and the busy window.
    task automatic rx_frame(input logic [7:0] d, input logic par, input string name,
                            output int wait_cyc, output logic empty_at_start);
        logic [10:0]    exp_bits;
        logic [CPB-1:0] samp;
        int             busy_cnt;
        exp_bits    = '1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
`ifdef RESP_UART_PARITY_EN
        exp_bits[9] = par;
`endif
        wait_cyc       = 0;
        empty_at_start = 1'bx;
        do begin
            @(negedge clk);
            wait_cyc++;
        end while (tx !== 1'b0 && wait_cyc < 300);
        if (tx !== 1'b0) begin
            check({name, " start timeout"}, 32'(tx), 32'd0);
            return;
        end
        empty_at_start = fifo_empty;
        busy_cnt       = 0;
        for (int b = 0; b < FRAME_BITS; b++) begin
            for (int s = 0; s < CPB; s++) begin
                if (b != 0 || s != 0) @(negedge clk);
                samp[s] = tx;
                if (tx_busy === 1'b1) busy_cnt++;
            end
            check($sformatf("%s bit%0d", name, b), 32'(samp), 32'({CPB{exp_bits[b]}}));
        end
        @(negedge clk);
        check({name, " busy cycles"}, 32'(busy_cnt), 32'(CPB * FRAME_BITS));
        check({name, " busy after"}, 32'(tx_busy), 32'd0);
    endtask

    initial begin
        int   w;
        int   c;
        logic e;

        vecs[0] = '{8'hA5, 1'b0, "vA5"};
        vecs[1] = '{8'h07, 1'b1, "v07"};
        vecs[2] = '{8'h03, 1'b0, "v03"};
        vecs[3] = '{8'h80, 1'b1, "v80"};
        vecs[4] = '{8'hFF, 1'b0, "vFF"};
        vecs[5] = '{8'h5A, 1'b0, "v5A"};

        repeat (3) @(negedge clk);
        check("rst tx", 32'(tx), 32'd1);
        check("rst busy", 32'(tx_busy), 32'd0);
        check("rst empty", 32'(fifo_empty), 32'd1);
        check("rst full", 32'(fifo_full), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single frames: tx falls two edges after the write edge.
        foreach (vecs[i]) begin
            write_byte(vecs[i].data);
            rx_frame(vecs[i].data, vecs[i].par, vecs[i].name, w, e);
            check({vecs[i].name, " latency"}, 32'(w), 32'd2);
        end

        // Back-to-back: exactly one idle-high clock between stop and next start.
        data_in    = 8'h3C;
        data_in_en = 1'b1;
        @(negedge clk);
        data_in    = 8'hC3;
        @(negedge clk);
        data_in_en = 1'b0;
        rx_frame(8'h3C, 1'b0, "b2b 3C", w, e);
        check("b2b 3C latency", 32'(w), 32'd1);
        rx_frame(8'hC3, 1'b0, "b2b C3", w, e);
        check("b2b gap", 32'(w), 32'd1);

        // Burst of 18 bytes: the 18th is dropped.
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    data_in    = 8'(i);
                    data_in_en = 1'b1;
                    @(negedge clk);
                    if (i == 15) check("burst full after 16", 32'(fifo_full), 32'd0);
                    if (i == 16) begin
                        check("burst full after 17", 32'(fifo_full), 32'd1);
                        check("burst no overflow 17", 32'(overflow), 32'd0);
                    end
                    if (i == 17) check("burst overflow 18", 32'(overflow), 32'd1);
                end
                data_in_en = 1'b0;
                @(negedge clk);
                check("burst overflow single", 32'(overflow), 32'd0);
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    logic [7:0] d;
                    d = 8'(i);
                    rx_frame(d, ^d, $sformatf("burst%0d", i), w, e);
                    if (i > 0)  check($sformatf("burst%0d gap", i), 32'(w), 32'd1);
                    if (i == 15) check("burst empty penultimate", 32'(e), 32'd0);
                    if (i == 16) check("burst empty last", 32'(e), 32'd1);
                end
            end
        join

        // Write while full on the same edge as a pop: still dropped, count 16 -> 15.
        for (int i = 0; i < 17; i++) begin
            data_in    = 8'(8'h20 + i);
            data_in_en = 1'b1;
            @(negedge clk);
        end
        check("pop full before", 32'(fifo_full), 32'd1);
        data_in = 8'hEE;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (tx_busy !== 1'b0 && c < 200);
        check("pop edge busy", 32'(tx_busy), 32'd0);
        check("pop edge overflow", 32'(overflow), 32'd1);
        check("pop edge full", 32'(fifo_full), 32'd0);
        data_in_en = 1'b0;
        @(negedge clk);
        check("pop after overflow", 32'(overflow), 32'd0);
        write_byte(8'h77);
        check("pop refill full", 32'(fifo_full), 32'd1);
        write_byte(8'h78);
        check("pop refill overflow", 32'(overflow), 32'd1);

        // Reset clears the FIFO; writes during reset are ignored.
        rst        = 1'b0;
        data_in    = 8'h99;
        data_in_en = 1'b1;
        repeat (2) @(negedge clk);
        data_in_en = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        check("post rst empty", 32'(fifo_empty), 32'd1);

        // Abandon a 0xFF frame at its 15th cycle.
        data_in    = 8'hFF;
        data_in_en = 1'b1;
        @(negedge clk);
        data_in    = 8'h12;
        @(negedge clk);
        data_in_en = 1'b0;
        c = 0;
        while (tx !== 1'b0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("abort frame started", 32'(tx), 32'd0);
        repeat (14) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort tx", 32'(tx), 32'd1);
        check("abort busy", 32'(tx_busy), 32'd0);
        check("abort empty", 32'(fifo_empty), 32'd1);
        check("abort full", 32'(fifo_full), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        write_byte(8'h55);
        rx_frame(8'h55, 1'b0, "after abort 55", w, e);
        check("after abort latency", 32'(w), 32'd2);
        check("after abort empty", 32'(fifo_empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
